// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencing controller: uop codes,
// FSM state encoding and the memory-uop classifier.
package pipe_pkg;

  localparam int unsigned UOP_W = 5;

  typedef logic [UOP_W-1:0] uop_t;

  localparam uop_t UOP_NOP = 5'd0;
  localparam uop_t UOP_ADD = 5'd1;
  localparam uop_t UOP_AND = 5'd3;
  localparam uop_t UOP_EOR = 5'd4;
  localparam uop_t UOP_CMP = 5'd5;
  localparam uop_t UOP_LSL = 5'd6;
  localparam uop_t UOP_MOV = 5'd8;
  localparam uop_t UOP_STR = 5'd9;
  localparam uop_t UOP_LDR = 5'd10;

  // Controller states.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FAULT    = 2'd3
  } state_e;

  // Loads and stores hold issue until data memory answers.
  function automatic logic is_mem_uop(input uop_t uop);
    return (uop == UOP_STR) || (uop == UOP_LDR);
  endfunction

endpackage : pipe_pkg

// File: rtl/pipe_ctrl_perf.sv
// Performance counters for pipe_ctrl: retired non-NOP uops and stall cycles
// (FLUSH or MEM_WAIT). Only instantiated when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_perf
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  state_e      i_state,
  input  logic        i_retire,
  output logic [31:0] o_retired_cnt,
  output logic [31:0] o_stall_cnt
);

  logic [31:0] r_retired_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_stalling;

  assign w_stalling = (i_state == ST_FLUSH) || (i_state == ST_MEM_WAIT);

  // Free-running wrap-around counters, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired_cnt <= '0;
      r_stall_cnt   <= '0;
    end else begin
      if (i_retire) begin
        r_retired_cnt <= r_retired_cnt + 32'd1;
      end
      if (w_stalling) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign o_retired_cnt = r_retired_cnt;
  assign o_stall_cnt   = r_stall_cnt;

endmodule : pipe_ctrl_perf

// File: rtl/pipe_ctrl.sv
// Sequencing controller between decode and execute. Issues one uop per cycle,
// owns the fetch PC, kills wrong-path slots after a taken branch and holds
// issue while an LDR/STR completes. Optional counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter logic [31:0] PC_RESET    = 32'h0,
  parameter int unsigned FLUSH_DEPTH = 2,   // 1..15
  parameter int unsigned MEM_TIMEOUT = 15   // 1..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  input  logic [4:0]  dec_uop,
  output logic        dec_ready,
  output logic [4:0]  exec_uop,
  input  logic        branch_taken,
  input  logic [31:0] delta_instruction,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        fetch_en,
  output logic        fault,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_DEPTH);
  localparam logic [7:0] TMO_LIMIT  = 8'(MEM_TIMEOUT);

  state_e      r_state;
  logic [31:0] r_pc;
  uop_t        r_exec_uop;
  logic        r_fault;
  logic [3:0]  r_flush_cnt;
  logic [7:0]  r_tmo_cnt;

  logic        w_run;
  logic        w_accept;
  logic [7:0]  w_tmo_next;

  assign w_run      = (r_state == ST_RUN);
  assign dec_ready  = w_run && !branch_taken;
  assign fetch_en   = w_run;
  assign w_accept   = dec_valid && dec_ready;
  assign w_tmo_next = r_tmo_cnt + 8'd1;

  // Controller FSM: issue, PC update, flush countdown and memory-wait timeout.
  // NOTE: every register here uses <= so all next-state terms read the
  // pre-edge values, regardless of statement order within the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_pc        <= PC_RESET;
      r_exec_uop  <= UOP_NOP;
      r_fault     <= 1'b0;
      r_flush_cnt <= '0;
      r_tmo_cnt   <= '0;
    end else begin
      // Only an accepted uop reaches execute; every other slot is a bubble.
      r_exec_uop <= w_accept ? dec_uop : UOP_NOP;

      case (r_state)
        ST_RUN: begin
          if (branch_taken) begin
            // Redirect fetch; any uop presented alongside is wrong-path.
            r_pc        <= r_pc + delta_instruction;
            r_flush_cnt <= FLUSH_INIT;
            r_state     <= ST_FLUSH;
          end else if (w_accept) begin
            r_pc <= r_pc + 32'd1;
            if (is_mem_uop(dec_uop)) begin
              r_tmo_cnt <= '0;
              r_state   <= ST_MEM_WAIT;
            end
          end
        end

        ST_FLUSH: begin
          // Slot count includes this cycle; leaving at 1 gives FLUSH_DEPTH
          // bubble cycles after the branch edge.
          if (r_flush_cnt <= 4'd1) begin
            r_state <= ST_RUN;
          end else begin
            r_flush_cnt <= r_flush_cnt - 4'd1;
          end
        end

        ST_MEM_WAIT: begin
          // A completion in the final allowed cycle still beats the timeout.
          if (mem_ready) begin
            r_state <= ST_RUN;
          end else begin
            r_tmo_cnt <= w_tmo_next;
            if (w_tmo_next == TMO_LIMIT) begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
            end
          end
        end

        ST_FAULT: begin
          // Absorbing: only reset leaves this state.
          r_state <= ST_FAULT;
        end

        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign pc       = r_pc;
  assign exec_uop = r_exec_uop;
  assign fault    = r_fault;

`ifdef PIPE_CTRL_PERF_EN
  logic w_retire;

  assign w_retire = w_accept && (dec_uop != UOP_NOP);

  pipe_ctrl_perf u_perf (
    .clk           (clk),
    .rst           (rst),
    .i_state       (r_state),
    .i_retire      (w_retire),
    .o_retired_cnt (retired_cnt),
    .o_stall_cnt   (stall_cnt)
  );
`else
  assign retired_cnt = 32'd0;
  assign stall_cnt   = 32'd0;
`endif

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: streaming issue, branch flush and PC wrap,
// memory wait, timeout fault, and reset during FLUSH.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        dec_valid;
  logic [4:0]  dec_uop;
  logic        dec_ready;
  logic [4:0]  exec_uop;
  logic        branch_taken;
  logic [31:0] delta_instruction;
  logic        mem_ready;
  logic [31:0] pc;
  logic        fetch_en;
  logic        fault;
  logic [31:0] retired_cnt;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipe_ctrl #(
    .PC_RESET    (32'h0),
    .FLUSH_DEPTH (2),
    .MEM_TIMEOUT (15)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .dec_valid         (dec_valid),
    .dec_uop           (dec_uop),
    .dec_ready         (dec_ready),
    .exec_uop          (exec_uop),
    .branch_taken      (branch_taken),
    .delta_instruction (delta_instruction),
    .mem_ready         (mem_ready),
    .pc                (pc),
    .fetch_en          (fetch_en),
    .fault             (fault),
    .retired_cnt       (retired_cnt),
    .stall_cnt         (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock edge, then settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag, input int exp_ret, input int exp_stall);
    check({tag, ".retired"}, retired_cnt, PERF ? 32'(exp_ret) : 32'd0);
    check({tag, ".stall"}, stall_cnt, PERF ? 32'(exp_stall) : 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst               = 1'b1;
    dec_valid         = 1'b0;
    dec_uop           = 5'd0;
    branch_taken      = 1'b0;
    delta_instruction = 32'd0;
    mem_ready         = 1'b0;
    #1;
    do_reset();

    // ---- reset state
    check("rst.pc", pc, 32'h0);
    check("rst.exec", exec_uop, 5'd0);
    check("rst.fault", fault, 1'b0);
    check("rst.ready", dec_ready, 1'b1);
    check("rst.fetch", fetch_en, 1'b1);
    check_counters("rst", 0, 0);

    // ---- streaming MOV, ADD, AND
    dec_valid = 1'b1;
    dec_uop = 5'd8; step();
    check("s1.exec", exec_uop, 5'd8); check("s1.pc", pc, 32'd1);
    dec_uop = 5'd1; step();
    check("s2.exec", exec_uop, 5'd1); check("s2.pc", pc, 32'd2);
    dec_uop = 5'd3; step();
    check("s3.exec", exec_uop, 5'd3); check("s3.pc", pc, 32'd3);
    dec_valid = 1'b0; step();
    check("s4.exec", exec_uop, 5'd0); check("s4.pc", pc, 32'd3);

    // ---- bring pc to 5, then branch +10 with a concurrent CMP
    dec_valid = 1'b1; dec_uop = 5'd1; step(); step();
    check("pre_br.pc", pc, 32'd5);
    branch_taken = 1'b1; delta_instruction = 32'd10; dec_uop = 5'd5;
    #1;
    check("br.ready_same_cycle", dec_ready, 1'b0);
    step();
    branch_taken = 1'b0; dec_valid = 1'b0;
    check("br.pc", pc, 32'd15);
    check("br.f1.exec", exec_uop, 5'd0);
    check("br.f1.ready", dec_ready, 1'b0);
    check("br.f1.fetch", fetch_en, 1'b0);
    step();
    check("br.f2.exec", exec_uop, 5'd0);
    check("br.f2.ready", dec_ready, 1'b0);
    step();
    check("br.run.ready", dec_ready, 1'b1);
    check("br.run.exec", exec_uop, 5'd0);
    check("br.run.pc", pc, 32'd15);
    check_counters("br", 5, 2);

    // ---- reset, pc to 3, branch -4 wraps to FFFFFFFF
    do_reset();
    check("rst2.pc", pc, 32'h0);
    check_counters("rst2", 0, 0);
    dec_valid = 1'b1; dec_uop = 5'd8;
    step(); step(); step();
    dec_valid = 1'b0;
    check("wrap.pre_pc", pc, 32'd3);
    branch_taken = 1'b1; delta_instruction = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    check("wrap.pc", pc, 32'hFFFF_FFFF);
    step(); step();
    check("wrap.ready", dec_ready, 1'b1);
    check_counters("wrap", 3, 2);

    // ---- STR with mem_ready in the 3rd wait cycle
    dec_valid = 1'b1; dec_uop = 5'd9;
    step();
    dec_valid = 1'b0;
    check("str.exec", exec_uop, 5'd9);
    check("str.pc", pc, 32'h0);
    check("str.ready", dec_ready, 1'b0);
    check("str.fetch", fetch_en, 1'b0);
    step();
    check("str.w1.exec", exec_uop, 5'd0); check("str.w1.pc", pc, 32'h0);
    step();
    check("str.w2.pc", pc, 32'h0); check("str.w2.ready", dec_ready, 1'b0);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("str.done.ready", dec_ready, 1'b1);
    check("str.done.pc", pc, 32'h0);
    check("str.done.fault", fault, 1'b0);
    check_counters("str", 4, 5);

    // ---- LDR with mem_ready in exactly the 15th wait cycle: no fault
    dec_valid = 1'b1; dec_uop = 5'd10;
    step();
    dec_valid = 1'b0;
    check("ldr1.exec", exec_uop, 5'd10);
    check("ldr1.pc", pc, 32'd1);
    for (int i = 0; i < 14; i++) step();
    check("ldr1.w15.fault", fault, 1'b0);
    check("ldr1.w15.ready", dec_ready, 1'b0);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("ldr1.done.fault", fault, 1'b0);
    check("ldr1.done.ready", dec_ready, 1'b1);
    check_counters("ldr1", 5, 20);

    // ---- LDR without mem_ready: fault after 15 wait cycles
    dec_valid = 1'b1; dec_uop = 5'd10;
    step();
    dec_valid = 1'b0;
    check("ldr2.pc", pc, 32'd2);
    for (int i = 0; i < 14; i++) step();
    check("ldr2.w15.fault", fault, 1'b0);
    check("ldr2.w15.fetch", fetch_en, 1'b0);
    step();
    check("ldr2.fault", fault, 1'b1);
    check("ldr2.fault.ready", dec_ready, 1'b0);
    check("ldr2.fault.fetch", fetch_en, 1'b0);
    // FAULT must ignore branches, uops and mem_ready.
    dec_valid = 1'b1; dec_uop = 5'd1; branch_taken = 1'b1;
    delta_instruction = 32'd7; mem_ready = 1'b1;
    step(); step(); step();
    dec_valid = 1'b0; branch_taken = 1'b0; mem_ready = 1'b0;
    check("flt.hold.fault", fault, 1'b1);
    check("flt.hold.pc", pc, 32'd2);
    check("flt.hold.exec", exec_uop, 5'd0);
    check("flt.hold.ready", dec_ready, 1'b0);
    check_counters("flt", 6, 35);

    // ---- reset clears the fault; then reset mid-FLUSH
    do_reset();
    check("rst3.fault", fault, 1'b0);
    check("rst3.ready", dec_ready, 1'b1);
    dec_valid = 1'b1; dec_uop = 5'd6;
    step();
    dec_valid = 1'b0;
    check("mf.pc1", pc, 32'd1);
    branch_taken = 1'b1; delta_instruction = 32'd10;
    step();
    branch_taken = 1'b0;
    check("mf.pc_target", pc, 32'd11);
    check("mf.in_flush", dec_ready, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mf.rst.pc", pc, 32'h0);
    check("mf.rst.exec", exec_uop, 5'd0);
    check("mf.rst.ready", dec_ready, 1'b1);
    check("mf.rst.fetch", fetch_en, 1'b1);
    check_counters("mf.rst", 0, 0);

    // ---- normal issue resumes straight after reset
    dec_valid = 1'b1; dec_uop = 5'd4;
    step();
    dec_valid = 1'b0;
    check("post.exec", exec_uop, 5'd4);
    check("post.pc", pc, 32'd1);
    check_counters("post", 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_pipe_ctrl
